// File: rtl/left_shift_ring_tx_pkg.sv
// Shared definitions for the ring transmitter: FSM encodings and default width.
// Encodings match the right-shift ring so both blocks decode state identically.
package left_shift_ring_tx_pkg;

   typedef logic [1:0] ring_state_t;

   localparam ring_state_t RING_IDLE  = 2'd0;
   localparam ring_state_t RING_SHIFT = 2'd1;
   localparam ring_state_t RING_DONE  = 2'd2;

   localparam int RING_WIDTH = 6;

endpackage

// File: rtl/left_shift_ring_tx_dff.sv
// Single-bit storage cell with synchronous clear and preset; clear wins over preset.
module left_shift_ring_tx_dff (
   input  logic clk,
   input  logic clear,
   input  logic preset,
   input  logic d,
   output logic q
);

   always_ff @(posedge clk) begin
      if (clear)
         q <= 1'b0;
      else if (preset)
         q <= 1'b1;
      else
         q <= d;
   end

endmodule

// File: rtl/left_shift_ring_tx.sv
// Parallel-in, MSB-first serial-out rotate-left ring transmitter with done pulse.
// Optional even-parity trailer beat when SHIFT_PARITY_EN is defined.
module left_shift_ring_tx
   import left_shift_ring_tx_pkg::*;
#(
   parameter int WIDTH = RING_WIDTH
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             ser_out,
   output logic             ser_valid,
   output logic [WIDTH-1:0] number,
   output logic             done
);

   localparam int CW = $clog2(WIDTH + 1);

`ifdef SHIFT_PARITY_EN
   // The parity beat is the extra SHIFT cycle where count has reached WIDTH.
   localparam logic [CW-1:0] LAST = CW'(WIDTH);
`else
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`endif

   ring_state_t      state;
   logic [CW-1:0]    count;
   logic             load;
   logic             shift;
   logic [WIDTH-1:0] d;

   assign in_ready  = (state == RING_IDLE) && !clr;
   assign load      = in_ready && in_valid;
   assign ser_valid = (state == RING_SHIFT) && !clr;
   assign done      = (state == RING_DONE) && !clr;

`ifdef SHIFT_PARITY_EN
   logic par;

   assign shift   = (state == RING_SHIFT) && (count != LAST);
   assign ser_out = ((state == RING_SHIFT) && (count == LAST)) ? par : number[WIDTH-1];

   always_ff @(posedge clk) begin
      if (clr)
         par <= 1'b0;
      else if (load)
         par <= ^in_data;
   end
`else
   assign shift   = (state == RING_SHIFT);
   assign ser_out = number[WIDTH-1];
`endif

   // Ring storage: bit i takes bit i-1 on a shift, bit 0 wraps from the MSB.
   for (genvar i = 0; i < WIDTH; i++) begin : g_ring
      assign d[i] = load  ? in_data[i] :
                    shift ? number[(i + WIDTH - 1) % WIDTH] :
                            number[i];

      left_shift_ring_tx_dff u_cell (
         .clk    (clk),
         .clear  (clr),
         .preset (1'b0),
         .d      (d[i]),
         .q      (number[i])
      );
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state <= RING_IDLE;
         count <= '0;
      end else begin
         case (state)
            RING_IDLE: begin
               if (load) begin
                  state <= RING_SHIFT;
                  count <= '0;
               end
            end
            RING_SHIFT: begin
               count <= count + CW'(1);
               if (count == LAST)
                  state <= RING_DONE;
            end
            RING_DONE: state <= RING_IDLE;
            default:   state <= RING_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_left_shift_ring_tx.sv
// Self-checking bench for left_shift_ring_tx (WIDTH=6); honours SHIFT_PARITY_EN.
module tb_left_shift_ring_tx;

   localparam int W = 6;
`ifdef SHIFT_PARITY_EN
   localparam int NB = W + 1;
`else
   localparam int NB = W;
`endif
   localparam int PER = NB + 2;

   logic         clk = 1'b0;
   logic         clr = 1'b1;
   logic         in_valid = 1'b0;
   logic [W-1:0] in_data = '0;
   logic         in_ready;
   logic         ser_out;
   logic         ser_valid;
   logic [W-1:0] number;
   logic         done;

   always #5 clk = ~clk;

   left_shift_ring_tx #(.WIDTH(W)) dut (
      .clk       (clk),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .ser_out   (ser_out),
      .ser_valid (ser_valid),
      .number    (number),
      .done      (done)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   bit chk_en = 1'b0;

   logic sb_bits[$];
   int   sb_cyc[$];
   int   acc_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [W-1:0] rotl(input logic [W-1:0] w, input int k);
      logic [2*W-1:0] t;
      t = {w, w} << k;
      return t[2*W-1:W];
   endfunction

   // Model: m_cnt 0 = idle, 1..NB = beat number, NB+1 = done cycle.
   int           m_cnt  = 0;
   logic [W-1:0] m_word = '0;
   logic [W-1:0] m_num  = '0;

   always @(posedge clk) begin
      cyc++;
      if (clr) begin
         m_cnt = 0;
         m_num = '0;
      end else if (m_cnt == 0) begin
         if (in_valid) begin
            m_word = in_data;
            m_num  = in_data;
            m_cnt  = 1;
         end
      end else if (m_cnt == NB + 1) begin
         m_cnt = 0;
      end else begin
         m_cnt++;
      end
   end

   always @(negedge clk) begin
      logic         e_rdy, e_sv, e_done, e_so;
      logic [W-1:0] e_num;
      int           k;
      if (chk_en) begin
         k      = m_cnt - 1;
         e_rdy  = !clr && (m_cnt == 0);
         e_sv   = !clr && (m_cnt >= 1) && (m_cnt <= NB);
         e_done = !clr && (m_cnt == NB + 1);
         e_num  = (m_cnt >= 1 && k < W) ? rotl(m_word, k) : m_num;
         e_so   = (k >= 0 && k < W) ? m_word[W-1-k] : ^m_word;
         chk("in_ready", in_ready, e_rdy);
         chk("ser_valid", ser_valid, e_sv);
         chk("done", done, e_done);
         chk("number", number, e_num);
         if (e_sv) chk("ser_out", ser_out, e_so);
      end
      if (!clr && in_valid && in_ready) acc_q.push_back(cyc);
      if (ser_valid) begin
         sb_bits.push_back(ser_out);
         sb_cyc.push_back(cyc);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic run_word(input logic [W-1:0] w, output logic [7:0] bits, output int nb);
      bit got_done;
      got_done = 1'b0;
      bits = '0;
      nb = 0;
      in_valid = 1'b1;
      in_data  = w;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ser_valid) begin
            bits = {bits[6:0], ser_out};
            nb++;
         end
         if (done) begin
            got_done = 1'b1;
            break;
         end
         tick();
      end
      chk("run_word_timeout", got_done, 1'b1);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [W-1:0] t2_num[W];
      logic [W-1:0] pres[64];
      logic [7:0]   bits;
      logic [15:0]  got, exp;
      int           nb, errs, seen;
      logic         eq[$];

      // 1: reset
      clr = 1'b1;
      tick();
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_number", number, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_ser_valid", ser_valid, 0);
      chk("rst_done", done, 0);
      tick();
      clr = 1'b0;
      @(negedge clk);
      chk("rst_ready_after", in_ready, 1);
      chk("rst_number_after", number, 0);

      // 2: single-one word, literal beats and ring contents
      t2_num = '{6'b100000, 6'b000001, 6'b000010, 6'b000100, 6'b001000, 6'b010000};
      bits = 8'b00100000;
      in_valid = 1'b1;
      in_data  = 6'b100000;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < W; k++) begin
         @(negedge clk);
         chk("t2_ser_valid", ser_valid, 1);
         chk("t2_ser_out", ser_out, bits[W-1-k]);
         chk("t2_number", number, t2_num[k]);
         tick();
      end
`ifdef SHIFT_PARITY_EN
      @(negedge clk);
      chk("t2_parity", ser_out, 1);
      chk("t2_parity_number", number, 6'b100000);
      tick();
`endif
      @(negedge clk);
      chk("t2_done", done, 1);
      chk("t2_done_number", number, 6'b100000);
      chk("t2_done_ready", in_ready, 0);
      tick();
      @(negedge clk);
      chk("t2_done_gone", done, 0);
      chk("t2_ready_back", in_ready, 1);

      // 3: literal streams incl. parity trailer
      run_word(6'b101100, bits, nb);
`ifdef SHIFT_PARITY_EN
      chk("t3_bits_a", bits, 8'b01011001);
      chk("t3_nb_a", nb, 7);
`else
      chk("t3_bits_a", bits, 8'b00101100);
      chk("t3_nb_a", nb, 6);
`endif
      run_word(6'b101101, bits, nb);
`ifdef SHIFT_PARITY_EN
      chk("t3_bits_b", bits, 8'b01011010);
`else
      chk("t3_bits_b", bits, 8'b00101101);
`endif

      // 4: in_valid held with new data every cycle
      @(negedge clk);
      tick();
      sb_bits.delete();
      sb_cyc.delete();
      acc_q.delete();
      for (int i = 0; i <= 3 * PER; i++) begin
         pres[i]  = W'(i * 7 + 3);
         in_valid = 1'b1;
         in_data  = pres[i];
         tick();
      end
      in_valid = 1'b0;
      repeat (PER + 2) tick();
      chk("t4_accepts", acc_q.size(), 4);
      for (int i = 1; i < acc_q.size(); i++)
         chk("t4_spacing", acc_q[i] - acc_q[i-1], PER);
      eq.delete();
      for (int j = 0; j < 4; j++) begin
         for (int b = W - 1; b >= 0; b--) eq.push_back(pres[j*PER][b]);
`ifdef SHIFT_PARITY_EN
         eq.push_back(^pres[j*PER]);
`endif
      end
      chk("t4_stream_len", sb_bits.size(), eq.size());
      errs = 0;
      for (int i = 0; i < eq.size() && i < sb_bits.size(); i++)
         if (sb_bits[i] !== eq[i]) errs++;
      chk("t4_stream_bits", errs, 0);

      // 5: clr during the 3rd beat aborts
      in_valid = 1'b1;
      in_data  = 6'b110101;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      clr = 1'b1;
      @(negedge clk);
      chk("t5_clr_ser_valid", ser_valid, 0);
      chk("t5_clr_done", done, 0);
      tick();
      clr = 1'b0;
      @(negedge clk);
      chk("t5_number", number, 0);
      chk("t5_ser_valid", ser_valid, 0);
      chk("t5_in_ready", in_ready, 1);
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         @(negedge clk);
         if (done || ser_valid) seen++;
      end
      chk("t5_no_done", seen, 0);

      // 6: back-to-back words
      tick();
      sb_bits.delete();
      sb_cyc.delete();
      in_valid = 1'b1;
      in_data  = 6'b011111;
      tick();
      in_data  = 6'b110000;
      repeat (PER) tick();
      in_valid = 1'b0;
      repeat (PER + 2) tick();
      got = '0;
      foreach (sb_bits[i]) got = {got[14:0], sb_bits[i]};
`ifdef SHIFT_PARITY_EN
      exp = 16'b00_0111111_1100000;
`else
      exp = 16'b0000_011111_110000;
`endif
      chk("t6_stream_len", sb_bits.size(), 2 * NB);
      chk("t6_stream", got, exp);
      if (sb_cyc.size() == 2 * NB) begin
         chk("t6_contig", sb_cyc[NB-1] - sb_cyc[0], NB - 1);
         chk("t6_gap", sb_cyc[NB] - sb_cyc[NB-1], 3);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
